// File: rtl/arb_bus_transfer_ctrl.sv
// Routes the granted master's write burst onto the shared slave port, counts beats and flags grant misuse.
// Optional stall timeout is enabled by defining BUS_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no owner; waiting for exactly one grant
// XFER    | driving the owner's beats onto the slave port
// DONE    | burst complete; m_done pulse for the owner
// RELEASE | waiting for the owner's grant to drop before accepting a new one
module arb_bus_transfer_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                grant0,
  input  logic                grant1,
  input  logic                grant2,
  input  logic                grant3,
  input  logic [4*ADDR_W-1:0] m_addr,
  input  logic [4*DATA_W-1:0] m_wdata,
  input  logic [4*LEN_W-1:0]  m_len,
  output logic [3:0]          m_wready,
  output logic [3:0]          m_done,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_ready,
  output logic [1:0]          owner,
  output logic                busy,
  output logic                grant_err,
  output logic                timeout
);

  typedef enum logic [1:0] {IDLE, XFER, DONE, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               s_valid_q, s_valid_d;
  logic [3:0]         m_done_q, m_done_d;
  logic               grant_err_q, grant_err_d;
  logic               busy_q, busy_d;

  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_any;
  logic       grant_multi;
  logic [3:0] own_oh;
  logic       owner_granted;
  logic       beat_acc;

  assign grant         = {grant3, grant2, grant1, grant0};
  assign grant_any     = |grant;
  assign grant_multi   = (grant & (grant - 4'd1)) != 4'd0;
  assign own_oh        = 4'd1 << owner_q;
  assign owner_granted = |(grant & own_oh);
  // A beat only counts while the owner still holds its grant; an abort cycle accepts nothing.
  assign beat_acc      = (state_q == XFER) && s_ready && owner_granted;

  always_comb begin
    grant_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) grant_idx = 2'(i);
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    m_done_d    = 4'd0;
    grant_err_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (grant_multi) begin
          grant_err_d = 1'b1;
        end else if (grant_any) begin
          owner_d    = grant_idx;
          base_d     = m_addr[grant_idx*ADDR_W +: ADDR_W];
          len_d      = m_len[grant_idx*LEN_W +: LEN_W];
          beat_cnt_d = '0;
          state_d    = XFER;
`ifdef BUS_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
        end
      end
      XFER: begin
        if (!owner_granted) begin
          grant_err_d = 1'b1;
          state_d     = IDLE;
        end else if (s_ready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
`ifdef BUS_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
          if (beat_cnt_q == len_q) begin
            m_done_d = own_oh;
            state_d  = DONE;
          end
        end
`ifdef BUS_TIMEOUT_EN
        // Report the stalled burst as finished so the master drops req and frees the bus.
        else if (stall_cnt_q == STALL_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          m_done_d  = own_oh;
          state_d   = RELEASE;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!owner_granted) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    s_valid_d = (state_d == XFER);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      base_q      <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      s_valid_q   <= 1'b0;
      m_done_q    <= 4'd0;
      grant_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      s_valid_q   <= s_valid_d;
      m_done_q    <= m_done_d;
      grant_err_q <= grant_err_d;
      busy_q      <= busy_d;
`ifdef BUS_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign s_valid   = s_valid_q;
  assign s_addr    = base_q + ADDR_W'(beat_cnt_q);
  assign s_wdata   = m_wdata[owner_q*DATA_W +: DATA_W];
  assign m_wready  = beat_acc ? own_oh : 4'd0;
  assign m_done    = m_done_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign grant_err = grant_err_q;
`ifdef BUS_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_arb_bus_transfer_ctrl.sv
// Scoreboard bench for arb_bus_transfer_ctrl: stimulus pushes expected beats/dones/errors, a negedge monitor pops and compares.
module tb_arb_bus_transfer_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          grant0, grant1, grant2, grant3;
  logic [4*AW-1:0] m_addr;
  logic [4*DW-1:0] m_wdata;
  logic [4*LW-1:0] m_len;
  logic [3:0]    m_wready;
  logic [3:0]    m_done;
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ready;
  logic [1:0]    owner;
  logic          busy;
  logic          grant_err;
  logic          timeout;

  arb_bus_transfer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(16)) dut (
    .clock(clock), .reset(reset),
    .grant0(grant0), .grant1(grant1), .grant2(grant2), .grant3(grant3),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_len(m_len),
    .m_wready(m_wready), .m_done(m_done),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready),
    .owner(owner), .busy(busy), .grant_err(grant_err), .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] mst;
  } beat_t;

  beat_t beat_q[$];
  int    done_q[$];
  int    pending_err = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  // Master model: each master advances its data on m_wready; data = {master, beat index}.
  logic [5:0] beat_idx [4] = '{default: 6'd0};

  always @(posedge clock) begin
    for (int n = 0; n < 4; n++) begin
      if (m_wready[n] === 1'b1) beat_idx[n] <= beat_idx[n] + 6'd1;
    end
  end

  always_comb begin
    m_wdata = '0;
    for (int n = 0; n < 4; n++) m_wdata[n*DW +: DW] = {2'(n), beat_idx[n]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_grant(input int n, input logic v);
    case (n)
      0: grant0 = v;
      1: grant1 = v;
      2: grant2 = v;
      default: grant3 = v;
    endcase
  endtask

  task automatic start_burst(input int n, input logic [7:0] addr, input logic [3:0] len,
                             input int nbeats, input bit expect_done);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.addr = addr + 8'(k);
      b.data = {2'(n), 6'(beat_idx[n] + 6'(k))};
      b.mst  = 2'(n);
      beat_q.push_back(b);
    end
    if (expect_done) done_q.push_back(n);
    m_addr[n*AW +: AW] = addr;
    m_len[n*LW +: LW]  = len;
    set_grant(n, 1'b1);
  endtask

  task automatic wait_for_done(input int n);
    int c = 0;
    do begin
      @(posedge clock); #1;
      c++;
    end while (m_done[n] !== 1'b1 && c < 200);
    chk($sformatf("done_seen_m%0d", n), 32'(m_done[n]), 32'd1);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy !== 1'b0 && c < 20) begin
      @(posedge clock); #1;
      c++;
    end
    chk("return_to_idle", 32'(busy), 32'd0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clock) begin
    beat_t e;
    int    d;
    if (|m_wready) begin
      chk("beat_expected", 32'(beat_q.size() != 0), 32'd1);
      if (beat_q.size() != 0) begin
        e = beat_q.pop_front();
        chk("beat_s_valid", 32'(s_valid), 32'd1);
        chk("beat_s_addr", 32'(s_addr), 32'(e.addr));
        chk("beat_s_wdata", 32'(s_wdata), 32'(e.data));
        chk("beat_m_wready", 32'(m_wready), 32'(4'd1 << e.mst));
        chk("beat_owner", 32'(owner), 32'(e.mst));
      end
    end
    if (|m_done) begin
      chk("done_expected", 32'(done_q.size() != 0), 32'd1);
      if (done_q.size() != 0) begin
        d = done_q.pop_front();
        chk("done_master", 32'(m_done), 32'(4'd1 << d));
        chk("done_no_valid", 32'(s_valid), 32'd0);
      end
    end
    if (grant_err === 1'b1) begin
      chk("grant_err_expected", 32'(pending_err > 0), 32'd1);
      if (pending_err > 0) pending_err--;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1;
    {grant3, grant2, grant1, grant0} = 4'b0000;
    m_addr = '0;
    m_len = '0;
    s_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_wready", 32'(m_wready), 32'd0);
    chk("rst_m_done", 32'(m_done), 32'd0);
    chk("rst_grant_err", 32'(grant_err), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_s_addr", 32'(s_addr), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Single burst, then hold grant in RELEASE while another master requests.
    s_ready = 1'b1;
    start_burst(1, 8'h10, 4'd3, 4, 1'b1);
    wait_for_done(1);
    grant0 = 1'b1;
    @(posedge clock); #1;
    chk("release_busy", 32'(busy), 32'd1);
    chk("release_owner", 32'(owner), 32'd1);
    chk("release_no_valid", 32'(s_valid), 32'd0);
    @(posedge clock); #1;
    chk("release_hold_busy", 32'(busy), 32'd1);
    chk("release_hold_owner", 32'(owner), 32'd1);
    grant1 = 1'b0;
    grant0 = 1'b0;
    wait_idle();

    // Backpressure: three stall cycles hold the base address.
    s_ready = 1'b0;
    start_burst(2, 8'h40, 4'd1, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("stall_s_valid", 32'(s_valid), 32'd1);
      chk("stall_s_addr", 32'(s_addr), 32'h40);
      chk("stall_m_wready", 32'(m_wready), 32'd0);
    end
    s_ready = 1'b1;
    wait_for_done(2);
    grant2 = 1'b0;
    wait_idle();

    // Address wrap.
    start_burst(0, 8'hFE, 4'd3, 4, 1'b1);
    wait_for_done(0);
    grant0 = 1'b0;
    wait_idle();

    // Multi-hot grant in IDLE.
    pending_err++;
    grant0 = 1'b1;
    grant3 = 1'b1;
    @(posedge clock); #1;
    grant0 = 1'b0;
    grant3 = 1'b0;
    chk("multihot_s_valid", 32'(s_valid), 32'd0);
    chk("multihot_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    chk("multihot_err_seen", 32'(pending_err), 32'd0);

    // Grant lost after two beats of eight, then a single-beat burst from master 0.
    start_burst(3, 8'h80, 4'd7, 2, 1'b0);
    pending_err++;
    repeat (3) @(posedge clock);
    #1;
    grant3 = 1'b0;
    @(posedge clock); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_s_valid", 32'(s_valid), 32'd0);
    chk("abort_m_done", 32'(m_done), 32'd0);
    @(posedge clock); #1;
    chk("abort_err_seen", 32'(pending_err), 32'd0);
    start_burst(0, 8'h20, 4'd0, 1, 1'b1);
    wait_for_done(0);
    grant0 = 1'b0;
    wait_idle();

    // Reset mid-burst: two beats go out, then everything clears without a done.
    start_burst(1, 8'h30, 4'd7, 2, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_s_valid", 32'(s_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_m_wready", 32'(m_wready), 32'd0);
    chk("midrst_m_done", 32'(m_done), 32'd0);
    chk("midrst_owner", 32'(owner), 32'd0);
    chk("midrst_s_addr", 32'(s_addr), 32'd0);
    grant1 = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;

`ifdef BUS_TIMEOUT_EN
    // Stall timeout: pulse after the 16th stalled XFER cycle.
    s_ready = 1'b0;
    start_burst(2, 8'h50, 4'd3, 0, 1'b1);
    c = 0;
    do begin
      @(posedge clock); #1;
      c++;
    end while (timeout !== 1'b1 && c < 40);
    chk("timeout_cycles", 32'(c), 32'd17);
    chk("timeout_s_valid", 32'(s_valid), 32'd0);
    chk("timeout_m_done", 32'(m_done), 32'b0100);
    grant2 = 1'b0;
    wait_idle();
    s_ready = 1'b1;
`else
    // Without the timeout the stalled burst waits indefinitely.
    s_ready = 1'b0;
    start_burst(2, 8'h50, 4'd0, 1, 1'b1);
    c = 0;
    repeat (100) begin
      @(posedge clock);
      c++;
    end
    #1;
    chk("nostall_s_valid", 32'(s_valid), 32'd1);
    chk("nostall_timeout", 32'(timeout), 32'd0);
    chk("nostall_s_addr", 32'(s_addr), 32'h50);
    s_ready = 1'b1;
    wait_for_done(2);
    grant2 = 1'b0;
    wait_idle();
`endif

    repeat (3) @(posedge clock);
    #1;
    chk("beats_left", 32'(beat_q.size()), 32'd0);
    chk("dones_left", 32'(done_q.size()), 32'd0);
    chk("errs_left", 32'(pending_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/arb_bus_transfer_ctrl.md
Name: arb_bus_transfer_ctrl

Overview:
- Downstream of the 4-master round-robin arbiter. Consumes its registered one-hot grants (grant3..grant0) and routes the winning master's burst onto a single shared slave write port.
- Counts beats and pulses per-master done. The master then drops its req, which makes the arbiter release the bus.
- Detects grant protocol violations: multi-hot grant, or grant lost mid-burst.

Parameters:
- ADDR_W, 8, address width per master and on slave port
- DATA_W, 8, write data width
- LEN_W, 4, burst length field width (beats minus 1, so 1..16 beats)
- TIMEOUT_CYC, 16, stall limit in cycles; used only when BUS_TIMEOUT_EN is defined

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- grant0..grant3  in  1 each  registered grants from arbiter
- m_addr  in  4*ADDR_W  start address; master n occupies slice [n*ADDR_W +: ADDR_W]
- m_wdata  in  4*DATA_W  current beat data, same slicing
- m_len  in  4*LEN_W  burst beats minus 1, same slicing
- m_wready  out  4  beat accepted for master n; master advances its data
- m_done  out  4  one-cycle pulse, burst for master n complete
- s_valid  out  1  slave write valid
- s_addr  out  ADDR_W  slave write address
- s_wdata  out  DATA_W  slave write data
- s_ready  in  1  slave accepts beat
- owner  out  2  encoded current owner; valid while busy=1
- busy  out  1  state != IDLE
- grant_err  out  1  one-cycle pulse on protocol violation
- timeout  out  1  one-cycle pulse on stall timeout; tied 0 without the macro

Behaviour:
- Reset is synchronous, active-high, clock is clock. On reset: state=IDLE and m_wready, m_done, s_valid, busy, grant_err, timeout all 0. owner=0, s_addr=0, beat_cnt=0. Reset mid-burst aborts with no done pulse.
- States are IDLE, XFER, DONE and RELEASE.
- IDLE, exactly one grant high: latch owner=index, base=m_addr[owner], len=m_len[owner], beat_cnt=0. Next state is XFER, so the first s_valid appears 1 cycle after grant is seen.
- IDLE, more than one grant high: grant_err=1 for one cycle; stay IDLE.
- IDLE, no grant: stay IDLE.
- XFER outputs:
  - s_valid=1
  - s_addr = base + beat_cnt, modulo 2^ADDR_W (wraps)
  - s_wdata = m_wdata[owner] (combinational select)
  - m_wready[owner] = s_ready; other m_wready bits are 0
- XFER beat handling: on s_valid & s_ready, beat_cnt++. If beat_cnt==len on that beat, next state is DONE.
- XFER, s_ready=0: hold address and count; s_valid stays high.
- XFER, grant[owner] drops before last beat: abort. s_valid=0 next cycle, grant_err pulse, no m_done, next state IDLE. If another grant is high in the same cycle, it is ignored that cycle.
- DONE: m_done[owner]=1 for exactly one cycle, s_valid=0. Next state is RELEASE.
- RELEASE: wait until grant[owner]==0 (master dropped req and arbiter cleared it), then go to IDLE. Other grants are ignored until IDLE, so there is at most one owner at a time.
- If grant[owner] is already 0 in DONE, RELEASE lasts one cycle.
- Burst of len=0 is a single beat; XFER to DONE on the first accepted beat.
- Minimum bus turnaround is IDLE→XFER→DONE→RELEASE→IDLE. Back-to-back bursts from different masters are separated by at least 3 non-valid cycles.
- busy=1 in XFER, DONE and RELEASE.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - stall counter resets on every accepted beat and on entering XFER
  - counter increments each XFER cycle with s_valid & ~s_ready
  - on reaching TIMEOUT_CYC: timeout=1 for one cycle, s_valid=0, m_done[owner] pulses, next state RELEASE; master sees completion and drops req
- Not defined: no counter logic, timeout tied 0, XFER waits on s_ready indefinitely.

Test Plan:
- Single burst: grant1=1, m_addr[1]=0x10, m_len[1]=3, s_ready=1 → s_valid for 4 cycles at addr 0x10..0x13, m_wready[1]=1 on each, m_done[1] pulse after last beat, owner=1.
- Backpressure: grant2, len=1, s_ready low 3 cycles then high → s_addr held at base during stall, exactly 2 accepted beats, single m_done[2].
- Address wrap: ADDR_W=8, m_addr[0]=0xFE, m_len[0]=3 → s_addr 0xFE, 0xFF, 0x00, 0x01.
- Multi-hot grant: grant0=grant3=1 in IDLE → grant_err pulse, s_valid stays 0, busy=0.
- Grant lost: grant3 dropped after 2 of 8 beats → grant_err pulse, no m_done, IDLE next; a following grant0 burst starts normally. Reset asserted mid-burst → all outputs 0 next cycle.
- With BUS_TIMEOUT_EN and TIMEOUT_CYC=16: s_ready held 0 → timeout pulse on 16th stall cycle, m_done[owner] pulse, s_valid=0; without the macro, s_valid stays high after 100 cycles.
